// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n}, the
// init sequencer state encoding and small elaboration-time helpers.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  // Address bit that selects "all banks" on PRECHARGE
  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    S_WAIT_PU,
    S_PRECHARGE,
    S_WAIT_RP,
    S_REFRESH,
    S_WAIT_RFC,
    S_LOAD_MODE,
    S_WAIT_MRD,
    S_DONE
  } init_state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_init_ctrl_if.sv
// SDRAM command bus plus init_done hand-off flag, as driven by the init sequencer.
interface sdram_init_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
);
  logic              sd_cke;
  logic              sd_cs_n;
  logic              sd_ras_n;
  logic              sd_cas_n;
  logic              sd_we_n;
  logic [ADDR_W-1:0] sd_addr;
  logic [BA_W-1:0]   sd_ba;
  logic              init_done;

  modport master (
    output sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_addr, sd_ba, init_done
  );

  modport slave (
    input sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_addr, sd_ba, init_done
  );
endinterface

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module sdram_wait_timer #(
  parameter int          W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up init sequencer: power-up wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE, then a sticky init_done that hands the bus to the arbiter.
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int                T_POWERUP_CYC = 20000,
  parameter int                T_RP_CYC      = 2,
  parameter int                T_RFC_CYC     = 7,
  parameter int                T_MRD_CYC     = 2,
  parameter int                N_REFRESH     = 2,
  parameter int                ADDR_W        = 13,
  parameter int                BA_W          = 2,
  parameter logic [ADDR_W-1:0] MODE_REG      = 'h032
) (
  input  logic              clk,
  input  logic              rst_n,
  sdram_init_ctrl_if.master sd
);

  localparam int T_MAX = max_of(max_of(T_POWERUP_CYC, T_RP_CYC), max_of(T_RFC_CYC, T_MRD_CYC));
  localparam int TW    = $clog2(T_MAX) + 1;
  localparam int RW    = $clog2(N_REFRESH + 1);

  init_state_e       state_q, state_d;
  logic              cke_q;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic              done_q, done_d;
  logic [RW-1:0]     ref_cnt_q, ref_cnt_d;

  logic              tmr_load;
  logic [TW-1:0]     tmr_load_val;
  logic              tmr_done;

  // Counting only starts once CKE is high, so the power-up wait spans exactly
  // T_POWERUP_CYC NOP cycles with CKE asserted.
  sdram_wait_timer #(
    .W       (TW),
    .RST_VAL (TW'(T_POWERUP_CYC - 1))
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (tmr_load),
    .load_value_i (tmr_load_val),
    .en_i         (cke_q),
    .done_o       (tmr_done)
  );

  // Wait states are loaded with T-2: one cycle is spent in the command state
  // and the exit cycle itself observes the zero count.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    ref_cnt_d    = ref_cnt_q;
    unique case (state_q)
      S_WAIT_PU:   if (cke_q && tmr_done) state_d = S_PRECHARGE;
      S_PRECHARGE: begin
        state_d      = S_WAIT_RP;
        tmr_load     = 1'b1;
        tmr_load_val = TW'(T_RP_CYC - 2);
      end
      S_WAIT_RP:   if (tmr_done) state_d = S_REFRESH;
      S_REFRESH: begin
        state_d      = S_WAIT_RFC;
        tmr_load     = 1'b1;
        tmr_load_val = TW'(T_RFC_CYC - 2);
        if (ref_cnt_q < RW'(N_REFRESH)) ref_cnt_d = ref_cnt_q + RW'(1);
      end
      S_WAIT_RFC: begin
        if (tmr_done) state_d = (ref_cnt_q < RW'(N_REFRESH)) ? S_REFRESH : S_LOAD_MODE;
      end
      S_LOAD_MODE: begin
        state_d      = S_WAIT_MRD;
        tmr_load     = 1'b1;
        tmr_load_val = TW'(T_MRD_CYC - 2);
      end
      S_WAIT_MRD:  if (tmr_done) state_d = S_DONE;
      S_DONE:      state_d = S_DONE;
      default:     state_d = S_WAIT_PU;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus lines up
  // with the state register.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    unique case (state_d)
      S_PRECHARGE: begin
        cmd_d           = CMD_PRECHARGE;
        addr_d[A10_BIT] = 1'b1;
      end
      S_REFRESH:   cmd_d = CMD_REFRESH;
      S_LOAD_MODE: begin
        cmd_d  = CMD_LOAD_MODE;
        addr_d = MODE_REG;
      end
      default:     cmd_d = CMD_NOP;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT_PU;
      cke_q     <= 1'b0;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      ba_q      <= '0;
      done_q    <= 1'b0;
      ref_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cke_q     <= 1'b1;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ba_q      <= ba_d;
      done_q    <= done_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  assign sd.sd_cke    = cke_q;
  assign sd.sd_cs_n   = cmd_q[3];
  assign sd.sd_ras_n  = cmd_q[2];
  assign sd.sd_cas_n  = cmd_q[1];
  assign sd.sd_we_n   = cmd_q[0];
  assign sd.sd_addr   = addr_q;
  assign sd.sd_ba     = ba_q;
  assign sd.init_done = done_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Bench for sdram_init_ctrl: three parameter sets, expected bus vectors queued
// on reset release and popped/compared every cycle.
module tb_sdram_init_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;

  sdram_init_ctrl_if #(.ADDR_W(13), .BA_W(2)) if_a ();
  sdram_init_ctrl_if #(.ADDR_W(13), .BA_W(2)) if_b ();
  sdram_init_ctrl_if #(.ADDR_W(13), .BA_W(2)) if_c ();

  sdram_init_ctrl #(.T_POWERUP_CYC(10), .T_RP_CYC(2), .T_RFC_CYC(7), .T_MRD_CYC(2),
                    .N_REFRESH(2), .ADDR_W(13), .BA_W(2), .MODE_REG(13'h032))
    dut_a (.clk(clk), .rst_n(rst_a), .sd(if_a));
  sdram_init_ctrl #(.T_POWERUP_CYC(10), .T_RP_CYC(2), .T_RFC_CYC(3), .T_MRD_CYC(2),
                    .N_REFRESH(8), .ADDR_W(13), .BA_W(2), .MODE_REG(13'h032))
    dut_b (.clk(clk), .rst_n(rst_b), .sd(if_b));
  sdram_init_ctrl #(.T_POWERUP_CYC(10), .T_RP_CYC(2), .T_RFC_CYC(2), .T_MRD_CYC(2),
                    .N_REFRESH(2), .ADDR_W(13), .BA_W(2), .MODE_REG(13'h032))
    dut_c (.clk(clk), .rst_n(rst_c), .sd(if_c));

  // Observed vector layout: {cke, cs_n, ras_n, cas_n, we_n, addr[12:0], ba[1:0], init_done}
  int          sel;
  logic [20:0] obs;
  always_comb begin
    case (sel)
      0:       obs = {if_a.sd_cke, if_a.sd_cs_n, if_a.sd_ras_n, if_a.sd_cas_n, if_a.sd_we_n,
                      if_a.sd_addr, if_a.sd_ba, if_a.init_done};
      1:       obs = {if_b.sd_cke, if_b.sd_cs_n, if_b.sd_ras_n, if_b.sd_cas_n, if_b.sd_we_n,
                      if_b.sd_addr, if_b.sd_ba, if_b.init_done};
      default: obs = {if_c.sd_cke, if_c.sd_cs_n, if_c.sd_ras_n, if_c.sd_cas_n, if_c.sd_we_n,
                      if_c.sd_addr, if_c.sd_ba, if_c.init_done};
    endcase
  end

  localparam logic [20:0] RESET_VEC = {1'b0, 4'b0111, 13'h0000, 2'b00, 1'b0};

  int          n_vec = 0;
  int          n_err = 0;
  logic [20:0] sb[$];

  task automatic check_vec(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference schedule for DUT s, k cycles after edge 0
  function automatic logic [20:0] exp_vec(input int s, input int k);
    int          tpu, trp, trfc, tmrd, nref, ld;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        done;
    tpu = 10; trp = 2; tmrd = 2;
    case (s)
      0:       begin trfc = 7; nref = 2; end
      1:       begin trfc = 3; nref = 8; end
      default: begin trfc = 2; nref = 2; end
    endcase
    cmd  = 4'b0111;
    addr = 13'h0000;
    if (k == tpu) begin
      cmd  = 4'b0010;
      addr = 13'h0400;
    end
    for (int i = 0; i < nref; i++)
      if (k == tpu + trp + i * trfc) cmd = 4'b0001;
    ld = tpu + trp + nref * trfc;
    if (k == ld) begin
      cmd  = 4'b0000;
      addr = 13'h0032;
    end
    done = (k >= ld + tmrd);
    return {1'b1, cmd, addr, 2'b00, done};
  endfunction

  task automatic set_rst(input int s, input logic v);
    case (s)
      0:       rst_a = v;
      1:       rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  // Called at a negedge with reset low: checks reset outputs, releases reset,
  // queues the expected schedule and compares n cycles of output.
  task automatic release_and_run(input int s, input int n);
    logic prev_cmd, cur_cmd;
    sel = s;
    #1 check_vec($sformatf("dut%0d reset", s), obs, RESET_VEC);
    @(negedge clk);
    set_rst(s, 1'b1);
    for (int k = 0; k < n; k++) sb.push_back(exp_vec(s, k));
    prev_cmd = 1'b0;
    for (int k = 0; k < n; k++) begin
      logic [20:0] e;
      @(negedge clk);
      e = sb.pop_front();
      check_vec($sformatf("dut%0d cyc%0d", s, k), obs, e);
      cur_cmd = (obs[19:16] != 4'b0111);
      check_vec($sformatf("dut%0d window cyc%0d", s, k), {20'd0, prev_cmd && cur_cmd}, 21'd0);
      prev_cmd = cur_cmd;
    end
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear immediately
  task automatic async_reset(input int s);
    sel = s;
    set_rst(s, 1'b0);
    #1 check_vec($sformatf("dut%0d async reset", s), obs, RESET_VEC);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    sel = 0;
    repeat (3) @(negedge clk);

    // Set A: partial run, reset between the two refreshes, then a full run
    release_and_run(0, 16);
    async_reset(0);
    release_and_run(0, 129);

    // Set C: minimum spacings; reset taken while in DONE, then full re-run
    release_and_run(2, 30);
    async_reset(2);
    release_and_run(2, 30);

    // Set B: eight refreshes three cycles apart
    release_and_run(1, 45);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
